mem_control: RTL and testbench

Memory-access decoder for the RISC-V datapath, in the execute stage between the ALU address output and the Dmem/Imem/IO blocks. Produces same-cycle byte write enables for data memory, instruction memory and the memory-mapped IO block, and an IO read strobe, from the instruction's opcode, funct3 and the effective address. Also registers a load descriptor that the writeback stage uses one cycle later to select and align load data.

---
 rtl/mem_control_if.sv | 29 ++
 rtl/mem_control.sv | 109 ++++++++++
 tb/tb_mem_control.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_control_if.sv
// Bus bundle for the memory-access decoder: request fields from the ALU
// stage, same-cycle write/read strobes, and the registered load descriptor.
interface mem_control_if;
  logic [6:0]  opcode;
  logic [2:0]  Funct3;
  logic [31:0] A;
  logic [3:0]  Dmem_enable;
  logic [3:0]  Imem_enable;
  logic [3:0]  Io_trans;
  logic        Io_recv;
  logic        Ld_valid;
  logic [1:0]  Ld_src;
  logic [2:0]  Ld_funct3;
  logic [1:0]  Ld_offset;

  // Requester side: issues the access and consumes the strobes/descriptor.
  modport master (
    output opcode, Funct3, A,
    input  Dmem_enable, Imem_enable, Io_trans, Io_recv,
    input  Ld_valid, Ld_src, Ld_funct3, Ld_offset
  );

  // Decoder side.
  modport slave (
    input  opcode, Funct3, A,
    output Dmem_enable, Imem_enable, Io_trans, Io_recv,
    output Ld_valid, Ld_src, Ld_funct3, Ld_offset
  );
endinterface

// File: rtl/mem_control.sv
// Memory-access decoder: combinational byte write enables for Dmem, Imem
// and IO plus an IO read strobe, and a one-cycle load descriptor that the
// writeback stage uses to pick and align load data.
module mem_control (
  input  logic         Clock,
  input  logic         Reset_n,
  mem_control_if.slave bus
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_DMEM = 2'b01;
  localparam logic [1:0] SRC_IO   = 2'b10;

  logic       is_load;
  logic       is_store;
  logic       in_dmem;
  logic       in_imem;
  logic       in_io;
  logic       store_width_ok;
  logic       load_width_ok;
  logic [3:0] lane_mask;

  logic       ld_valid_reg,  ld_valid_next;
  logic [1:0] ld_src_reg,    ld_src_next;
  logic [2:0] ld_funct3_reg, ld_funct3_next;
  logic [1:0] ld_offset_reg, ld_offset_next;

  assign is_load  = (bus.opcode == OPC_LOAD);
  assign is_store = (bus.opcode == OPC_STORE);

  // Region 0011 aliases both Dmem and Imem, so the two decodes overlap.
  assign in_dmem = (bus.A[31:28] == 4'b0001) || (bus.A[31:28] == 4'b0011);
  assign in_imem = (bus.A[31:28] == 4'b0010) || (bus.A[31:28] == 4'b0011);
  assign in_io   = (bus.A[31:28] == 4'b1000);

  // Store width lane mask; halfword placement uses A[1] only.
  always_comb begin
    lane_mask      = 4'b0000;
    store_width_ok = 1'b0;
    case (bus.Funct3)
      3'b000: begin
        lane_mask      = 4'b0001 << bus.A[1:0];
        store_width_ok = 1'b1;
      end
      3'b001: begin
        lane_mask      = bus.A[1] ? 4'b1100 : 4'b0011;
        store_width_ok = 1'b1;
      end
      3'b010: begin
        lane_mask      = 4'b1111;
        store_width_ok = 1'b1;
      end
      default: begin
        lane_mask      = 4'b0000;
        store_width_ok = 1'b0;
      end
    endcase
  end

  assign load_width_ok = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001) ||
                         (bus.Funct3 == 3'b010) || (bus.Funct3 == 3'b100) ||
                         (bus.Funct3 == 3'b101);

  // Per-lane write enables; IO takes the whole word for any valid width.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign bus.Dmem_enable[gi] = is_store && in_dmem && lane_mask[gi];
      assign bus.Imem_enable[gi] = is_store && in_imem && lane_mask[gi];
      assign bus.Io_trans[gi]    = is_store && in_io && store_width_ok;
    end
  endgenerate

  assign bus.Io_recv = is_load && in_io;

  // Next load descriptor: only Dmem and IO are readable.
  always_comb begin
    ld_valid_next  = is_load && load_width_ok && (in_dmem || in_io);
    ld_src_next    = SRC_NONE;
    if (ld_valid_next) begin
      ld_src_next  = in_io ? SRC_IO : SRC_DMEM;
    end
    ld_funct3_next = bus.Funct3;
    ld_offset_next = bus.A[1:0];
  end

  // Descriptor register, rewritten every edge; reset wins over a load.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ld_valid_reg  <= 1'b0;
      ld_src_reg    <= SRC_NONE;
      ld_funct3_reg <= 3'b000;
      ld_offset_reg <= 2'b00;
    end else begin
      ld_valid_reg  <= ld_valid_next;
      ld_src_reg    <= ld_src_next;
      ld_funct3_reg <= ld_funct3_next;
      ld_offset_reg <= ld_offset_next;
    end
  end

  assign bus.Ld_valid  = ld_valid_reg;
  assign bus.Ld_src    = ld_src_reg;
  assign bus.Ld_funct3 = ld_funct3_reg;
  assign bus.Ld_offset = ld_offset_reg;

endmodule

// File: tb/tb_mem_control.sv
// Bench for mem_control: directed plus random accesses, expected responses
// queued by the driver and checked by independent monitors.
module tb_mem_control;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct {
    logic [3:0] dmem;
    logic [3:0] imem;
    logic [3:0] io;
    logic       recv;
  } comb_t;

  typedef struct {
    logic       valid;
    logic [1:0] src;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_t;

  logic Clock;
  logic Reset_n;
  mem_control_if bus ();

  mem_control dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  comb_t comb_q[$];
  ld_t   ld_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done   = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model written from the region/width rules.
  function automatic comb_t model_comb(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [31:0] a);
    comb_t r;
    int    region;
    int    mask;
    bit    dm, im, io;
    region = int'(a[31:28]);
    dm = (region == 1) || (region == 3);
    im = (region == 2) || (region == 3);
    io = (region == 8);
    case (f3)
      3'd0:    mask = 1 << int'(a[1:0]);
      3'd1:    mask = 3 << (2 * int'(a[1]));
      3'd2:    mask = 15;
      default: mask = 0;
    endcase
    r.dmem = 4'd0; r.imem = 4'd0; r.io = 4'd0; r.recv = 1'b0;
    if (opc == OPC_STORE) begin
      if (dm) r.dmem = mask[3:0];
      if (im) r.imem = mask[3:0];
      if (io && mask != 0) r.io = 4'hF;
    end else if (opc == OPC_LOAD) begin
      r.recv = io;
    end
    return r;
  endfunction

  function automatic ld_t model_ld(input logic rst_n, input logic [6:0] opc,
                                   input logic [2:0] f3, input logic [31:0] a);
    ld_t r;
    bit  f3_ok;
    r.valid = 1'b0; r.src = 2'b00; r.f3 = 3'd0; r.off = 2'd0;
    if (rst_n) begin
      f3_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      r.f3  = f3;
      r.off = a[1:0];
      if (opc == OPC_LOAD && f3_ok) begin
        if (a[31:28] == 4'h8) begin
          r.valid = 1'b1; r.src = 2'b10;
        end else if (a[31:28] == 4'h1 || a[31:28] == 4'h3) begin
          r.valid = 1'b1; r.src = 2'b01;
        end
      end
    end
    return r;
  endfunction

  task automatic drive(input logic rst_n, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] a);
    @(negedge Clock);
    Reset_n    = rst_n;
    bus.opcode = opc;
    bus.Funct3 = f3;
    bus.A      = a;
    comb_q.push_back(model_comb(opc, f3, a));
    ld_q.push_back(model_ld(rst_n, opc, f3, a));
    $display("txn rst_n=%0b opc=%07b f3=%03b A=%08h", rst_n, opc, f3, a);
  endtask

  // Combinational monitor: outputs settle shortly after the driver's update.
  initial begin
    comb_t e;
    forever begin
      @(negedge Clock);
      #2;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        chk("dmem_enable", 32'(bus.Dmem_enable), 32'(e.dmem));
        chk("imem_enable", 32'(bus.Imem_enable), 32'(e.imem));
        chk("io_trans",    32'(bus.Io_trans),    32'(e.io));
        chk("io_recv",     32'(bus.Io_recv),     32'(e.recv));
      end
    end
  end

  // Descriptor monitor: checked one rising edge after each transaction.
  initial begin
    ld_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (ld_q.size() > 0) begin
        e = ld_q.pop_front();
        chk("ld_valid",  32'(bus.Ld_valid),  32'(e.valid));
        chk("ld_src",    32'(bus.Ld_src),    32'(e.src));
        chk("ld_funct3", 32'(bus.Ld_funct3), 32'(e.f3));
        chk("ld_offset", 32'(bus.Ld_offset), 32'(e.off));
      end
    end
  end

  // Stimulus: directed cases from the access rules, then random traffic.
  initial begin
    logic [6:0]  opc;
    logic [31:0] a;
    logic [3:0]  nib;
    Reset_n    = 1'b0;
    bus.opcode = 7'd0;
    bus.Funct3 = 3'd0;
    bus.A      = 32'd0;

    drive(1'b0, OPC_LOAD,  3'd0, 32'h1000_0001); // reset overrides a Dmem load
    drive(1'b0, OPC_LOAD,  3'd2, 32'h8000_0003);
    drive(1'b1, OPC_LOAD,  3'd0, 32'h8000_0000);
    drive(1'b1, OPC_LOAD,  3'd1, 32'h1000_0000);
    drive(1'b1, OPC_LOAD,  3'd4, 32'h1000_0000);
    drive(1'b1, OPC_LOAD,  3'd5, 32'h1000_0002);
    drive(1'b1, OPC_STORE, 3'd0, 32'h1000_0003);
    drive(1'b1, OPC_STORE, 3'd1, 32'h1000_0002);
    drive(1'b1, OPC_STORE, 3'd1, 32'h1000_0001);
    drive(1'b1, OPC_STORE, 3'd0, 32'h8000_0004);
    drive(1'b1, OPC_STORE, 3'd2, 32'h3000_0000);
    drive(1'b1, OPC_STORE, 3'd0, 32'h2000_0001);
    drive(1'b1, OPC_STORE, 3'd3, 32'h8000_0000); // invalid store width to IO
    drive(1'b1, OPC_LOAD,  3'd2, 32'h2000_0000); // Imem-only not readable
    drive(1'b1, OPC_LOAD,  3'd2, 32'h3000_0001);
    drive(1'b1, OPC_LOAD,  3'd6, 32'h1000_0000); // invalid load width
    drive(1'b1, OPC_LOAD,  3'd2, 32'h4000_0000); // unmapped
    drive(1'b1, 7'b0110011, 3'd2, 32'h3000_0000); // non-memory opcode
    drive(1'b1, OPC_LOAD,  3'd2, 32'h1000_0000);
    drive(1'b0, OPC_LOAD,  3'd2, 32'h1000_0000);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    opc = OPC_LOAD;
        2, 3:    opc = OPC_STORE;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       nib = 4'h1;
        1:       nib = 4'h2;
        2:       nib = 4'h3;
        3:       nib = 4'h8;
        default: nib = 4'($urandom);
      endcase
      a = {nib, 28'($urandom)};
      drive(($urandom_range(0, 15) != 0), opc, 3'($urandom), a);
    end

    repeat (3) @(negedge Clock);
    chk("comb_queue_drained", 32'(comb_q.size()), 32'd0);
    chk("ld_queue_drained",   32'(ld_q.size()),   32'd0);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
